// File: rtl/ht_loader_pkg.sv
// Shared types and record decoding for the hps_io download loaders.
package ht_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_TYPE, S_LEN, S_ADDR_LO, S_ADDR_HI, S_DATA, S_SKIP, S_XLO, S_XHI, S_DONE
    } state_t;

    typedef enum logic [1:0] {M_IDLE, M_CMD, M_RAW} mode_t;

    typedef enum logic [1:0] {K_LOAD, K_XFER, K_SKIP} rec_kind_t;

    localparam logic [7:0] REC_LOAD = 8'h01;
    localparam logic [7:0] REC_XFER = 8'h02;
    localparam logic [7:0] REC_NAME = 8'h05;

    function automatic rec_kind_t classify(input logic [7:0] rec_type);
        case (rec_type)
            REC_LOAD: return K_LOAD;
            REC_XFER: return K_XFER;
            REC_NAME: return K_SKIP;
            default:  return K_SKIP;
        endcase
    endfunction

    // Load length includes the two address bytes; small values wrap into 254..256.
    function automatic logic [8:0] load_count(input logic [7:0] len);
        return (len >= 8'd3) ? ({1'b0, len} - 9'd2) : ({1'b0, len} + 9'd254);
    endfunction

    function automatic logic [8:0] skip_count(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/loader_wr_hs.sv
// Single-entry write holding register: presents one RAM write until accepted
// and stalls the byte source while it is occupied.
module loader_wr_hs #(
    parameter int AW = 16
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [7:0]    push_data,
    input  logic          ready,
    output logic          wr,
    output logic [AW-1:0] addr,
    output logic [7:0]    data,
    output logic          stall
);

    logic          valid_reg;
    logic [AW-1:0] addr_reg;
    logic [7:0]    data_reg;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            valid_reg <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
        end else if (push && !valid_reg) begin
            valid_reg <= 1'b1;
            addr_reg  <= push_addr;
            data_reg  <= push_data;
        end else if (valid_reg && ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign wr    = valid_reg;
    assign addr  = addr_reg;
    assign data  = data_reg;
    assign stall = valid_reg;

endmodule

// File: rtl/cmd_multi_loader.sv
// Download loader for TRS-80 /CMD record files and raw binary images,
// feeding the core's RAM port through a ready/valid write register.
module cmd_multi_loader
    import ht_loader_pkg::*;
#(
    parameter int            AW        = 16,
    parameter logic [7:0]    CMD_INDEX = 8'd2,
    parameter logic [7:0]    RAW_INDEX = 8'd3,
    parameter logic [AW-1:0] RAW_BASE  = AW'('h5200)
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [7:0]    ioctl_dout,
    input  logic [7:0]    ioctl_index,
    output logic          ioctl_wait,
    output logic          loader_download,
    output logic          loader_wr,
    input  logic          loader_ready,
    output logic [AW-1:0] loader_addr,
    output logic [7:0]    loader_data,
    output logic [AW-1:0] execute_addr,
    output logic          execute_enable,
    output logic          err
);

    state_t        state_reg, state_next;
    mode_t         mode_reg;
    rec_kind_t     kind_reg;
    logic [8:0]    count_reg;
    logic [AW-1:0] addr_reg, exec_addr_reg;
    logic          xfer_seen_reg, err_reg, ending_reg, download_reg, exec_en_reg, dl_prev_reg;

    logic active, start, end_evt, byte_in, violation, byte_ok, truncated, finish, fire, push;

    assign active    = (mode_reg != M_IDLE);
    assign start     = ioctl_download && !dl_prev_reg && !active &&
                       (ioctl_index == CMD_INDEX || ioctl_index == RAW_INDEX);
    assign end_evt   = !ioctl_download && dl_prev_reg && active && !ending_reg;
    assign byte_in   = ioctl_wr && ioctl_download && active && !ending_reg;
    assign violation = byte_in && ioctl_wait;
    assign byte_ok   = byte_in && !ioctl_wait;
    assign truncated = end_evt && (mode_reg == M_CMD) &&
                       !(state_reg == S_TYPE || state_reg == S_DONE);
    // The session closes only once the last write has left the holding register.
    assign finish    = (end_evt || ending_reg) && (!loader_wr || loader_ready);
    assign fire      = finish && (mode_reg == M_CMD) && xfer_seen_reg &&
                       !err_reg && !truncated && !violation;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) state_reg <= S_IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (start) begin
            state_next = (ioctl_index == CMD_INDEX) ? S_TYPE : S_IDLE;
        end else if (finish) begin
            state_next = S_IDLE;
        end else if (byte_ok && mode_reg == M_CMD) begin
            case (state_reg)
                S_TYPE:    state_next = S_LEN;
                S_LEN: begin
                    if (kind_reg == K_LOAD)      state_next = S_ADDR_LO;
                    else if (kind_reg == K_XFER) state_next = S_XLO;
                    else                         state_next = S_SKIP;
                end
                S_ADDR_LO: state_next = S_ADDR_HI;
                S_ADDR_HI: state_next = S_DATA;
                S_DATA, S_SKIP: begin
                    if (count_reg == 9'd1) state_next = S_TYPE;
                end
                S_XLO:     state_next = S_XHI;
                S_XHI:     state_next = S_DONE;
                default:   state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        push = 1'b0;
        if (byte_ok) push = (mode_reg == M_RAW) || (state_reg == S_DATA);
    end

    always_ff @(posedge clk_sys) begin
        // Edge tracker runs through reset so a download held high does not re-trigger.
        dl_prev_reg <= ioctl_download;
        exec_en_reg <= 1'b0;
        if (!reset_n) begin
            mode_reg      <= M_IDLE;
            kind_reg      <= K_SKIP;
            count_reg     <= '0;
            addr_reg      <= '0;
            exec_addr_reg <= '0;
            xfer_seen_reg <= 1'b0;
            err_reg       <= 1'b0;
            ending_reg    <= 1'b0;
            download_reg  <= 1'b0;
        end else if (start) begin
            mode_reg      <= (ioctl_index == CMD_INDEX) ? M_CMD : M_RAW;
            addr_reg      <= RAW_BASE;
            xfer_seen_reg <= 1'b0;
            err_reg       <= 1'b0;
            ending_reg    <= 1'b0;
            download_reg  <= 1'b1;
        end else if (active) begin
            if (violation || truncated) err_reg <= 1'b1;
            if (end_evt) ending_reg <= 1'b1;
            if (finish) begin
                mode_reg     <= M_IDLE;
                ending_reg   <= 1'b0;
                download_reg <= 1'b0;
                exec_en_reg  <= fire;
            end
            if (byte_ok) begin
                if (mode_reg == M_RAW) begin
                    addr_reg <= addr_reg + AW'(1);
                end else begin
                    case (state_reg)
                        S_TYPE:    kind_reg <= classify(ioctl_dout);
                        S_LEN:     count_reg <= (kind_reg == K_LOAD) ? load_count(ioctl_dout)
                                                                     : skip_count(ioctl_dout);
                        S_ADDR_LO: addr_reg <= {addr_reg[AW-1:8], ioctl_dout};
                        S_ADDR_HI: addr_reg <= AW'({ioctl_dout, addr_reg[7:0]});
                        S_DATA: begin
                            addr_reg  <= addr_reg + AW'(1);
                            count_reg <= count_reg - 9'd1;
                        end
                        S_SKIP:    count_reg <= count_reg - 9'd1;
                        S_XLO:     exec_addr_reg <= {exec_addr_reg[AW-1:8], ioctl_dout};
                        S_XHI: begin
                            exec_addr_reg <= AW'({ioctl_dout, exec_addr_reg[7:0]});
                            xfer_seen_reg <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    loader_wr_hs #(.AW(AW)) u_wr_hs (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .push      (push),
        .push_addr (addr_reg),
        .push_data (ioctl_dout),
        .ready     (loader_ready),
        .wr        (loader_wr),
        .addr      (loader_addr),
        .data      (loader_data),
        .stall     (ioctl_wait)
    );

    assign loader_download = download_reg;
    assign execute_addr    = exec_addr_reg;
    assign execute_enable  = exec_en_reg;
    assign err             = err_reg;

endmodule

// File: tb/tb_cmd_multi_loader.sv
// Directed bench: record-level /CMD and raw models feed a write scoreboard
// checked every cycle, plus literal pins on the model and DUT.
module tb_cmd_multi_loader;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_dout = 8'h00;
    logic [7:0]  ioctl_index = 8'h00;
    logic        loader_ready = 1'b1;
    logic        ioctl_wait, loader_download, loader_wr, execute_enable, err;
    logic [15:0] loader_addr, execute_addr;
    logic [7:0]  loader_data;

    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          wr_run = 0;
    int          max_run = 0;
    int          stall_cnt = 0;
    logic [7:0]  stream[$];
    wr_t         exp_q[$];
    logic        exp_xfer, exp_clean;
    logic [15:0] exp_exec;

    always #5 clk_sys = ~clk_sys;

    cmd_multi_loader #(.AW(16), .CMD_INDEX(8'd2), .RAW_INDEX(8'd3), .RAW_BASE(16'hFFFF)) dut (
        .clk_sys         (clk_sys),
        .reset_n         (reset_n),
        .ioctl_download  (ioctl_download),
        .ioctl_wr        (ioctl_wr),
        .ioctl_dout      (ioctl_dout),
        .ioctl_index     (ioctl_index),
        .ioctl_wait      (ioctl_wait),
        .loader_download (loader_download),
        .loader_wr       (loader_wr),
        .loader_ready    (loader_ready),
        .loader_addr     (loader_addr),
        .loader_data     (loader_data),
        .execute_addr    (execute_addr),
        .execute_enable  (execute_enable),
        .err             (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Record-level /CMD model: expected writes, transfer address, clean end.
    task automatic model_cmd();
        int   i, n, cnt;
        bit   stop;
        logic [7:0]  typ, len;
        logic [15:0] a;
        n = stream.size(); i = 0; stop = 0;
        exp_clean = 1'b1; exp_xfer = 1'b0; exp_exec = 16'h0000;
        exp_q.delete();
        while (i < n && !stop) begin
            typ = stream[i];
            if (i + 1 >= n) begin
                exp_clean = 1'b0; stop = 1;
            end else begin
                len = stream[i+1];
                i += 2;
                if (typ == 8'h01) begin
                    cnt = (len >= 3) ? int'(len) - 2 : int'(len) + 254;
                    if (i + 2 > n) begin
                        exp_clean = 1'b0; stop = 1;
                    end else begin
                        a = {stream[i+1], stream[i]};
                        i += 2;
                        for (int k = 0; k < cnt; k++) begin
                            if (i >= n) begin
                                exp_clean = 1'b0; stop = 1;
                                break;
                            end
                            exp_q.push_back({a + 16'(k), stream[i]});
                            i++;
                        end
                    end
                end else if (typ == 8'h02) begin
                    if (i + 2 > n) begin
                        exp_clean = 1'b0;
                    end else begin
                        exp_exec = {stream[i+1], stream[i]};
                        exp_xfer = 1'b1;
                    end
                    stop = 1;
                end else begin
                    cnt = (len == 0) ? 256 : int'(len);
                    if (i + cnt > n) begin
                        exp_clean = 1'b0; stop = 1;
                    end else begin
                        i += cnt;
                    end
                end
            end
        end
    endtask

    task automatic model_raw(input logic [15:0] base);
        exp_q.delete();
        exp_clean = 1'b1; exp_xfer = 1'b0; exp_exec = 16'h0000;
        for (int k = 0; k < stream.size(); k++) exp_q.push_back({base + 16'(k), stream[k]});
    endtask

    task automatic start_dl(input logic [7:0] idx, input logic exp_dl);
        ioctl_index = idx;
        ioctl_download = 1'b1;
        tick();
        tick();
        check("start_download", loader_download, exp_dl);
        if (exp_dl) check("start_err_clear", err, 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        ioctl_dout = b;
        ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        n = 0;
        while (ioctl_wait && n < 200) begin
            tick();
            n++;
        end
        check("wait_release", ioctl_wait, 0);
    endtask

    task automatic end_dl();
        int n;
        ioctl_download = 1'b0;
        n = 0;
        while (loader_download && n < 100) begin
            tick();
            n++;
        end
        check("download_drop", loader_download, 0);
        repeat (3) tick();
    endtask

    task automatic run_dl(input string name, input logic [7:0] idx, input bit is_cmd);
        pulses = 0;
        start_dl(idx, 1'b1);
        foreach (stream[k]) send_byte(stream[k]);
        end_dl();
        check({name, "_drain"}, exp_q.size(), 0);
        check({name, "_pulse"}, pulses, (is_cmd && exp_xfer && exp_clean) ? 1 : 0);
        check({name, "_err"}, err, exp_clean ? 0 : 1);
        if (is_cmd && exp_xfer) check({name, "_exec"}, execute_addr, exp_exec);
        $display("%s: %0d checks so far, %0d errors", name, checks, errors);
    endtask

    // RAM-side ready: optionally stall the first cycles of the next write.
    initial begin
        forever begin
            @(posedge clk_sys);
            #1;
            if (loader_wr && stall_cnt > 0) begin
                loader_ready = 1'b0;
                stall_cnt--;
            end else begin
                loader_ready = 1'b1;
            end
        end
    end

    // Per-cycle compare against the scoreboard and handshake rules.
    logic        hold_v = 1'b0;
    logic [23:0] hold_w;
    wr_t         got_w, want_w;
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            hold_v = 1'b0;
            wr_run = 0;
        end else begin
            check("wait_tracks_wr", ioctl_wait, loader_wr);
            if (hold_v) check("held_write_stable", {loader_wr, loader_addr, loader_data}, {1'b1, hold_w});
            if (loader_wr && loader_ready) begin
                got_w = {loader_addr, loader_data};
                if (exp_q.size() == 0) begin
                    check("unexpected_write", got_w, 24'h0);
                    errors += (got_w == 24'h0) ? 1 : 0;
                end else begin
                    want_w = exp_q.pop_front();
                    check("write_addr_data", got_w, want_w);
                end
            end
            hold_v = loader_wr && !loader_ready;
            hold_w = {loader_addr, loader_data};
            wr_run = loader_wr ? wr_run + 1 : 0;
            if (wr_run > max_run) max_run = wr_run;
            if (execute_enable) begin
                pulses++;
                check("pulse_with_drop", loader_download, 0);
            end
        end
    end

    initial begin
        repeat (3) tick();
        check("rst_download", loader_download, 0);
        check("rst_wr_wait", {loader_wr, ioctl_wait}, 0);
        check("rst_exec", {execute_enable, execute_addr}, 0);
        check("rst_err", err, 0);
        reset_n = 1'b1;
        tick();

        // Load + transfer record
        stream = '{8'h01, 8'h05, 8'h00, 8'h40, 8'hAA, 8'hBB, 8'hCC, 8'h02, 8'h02, 8'h00, 8'h52};
        model_cmd();
        check("model1_count", exp_q.size(), 3);
        check("model1_first", exp_q[0], {16'h4000, 8'hAA});
        check("model1_last", exp_q[2], {16'h4002, 8'hCC});
        check("model1_exec", exp_exec, 16'h5200);
        run_dl("cmd_basic", 8'd2, 1'b1);
        check("cmd_basic_exec_lit", execute_addr, 16'h5200);

        // len=2 load record carries 256 bytes
        stream = '{8'h01, 8'h02, 8'h00, 8'h30};
        for (int k = 0; k < 256; k++) stream.push_back(8'(k) ^ 8'h5A);
        model_cmd();
        check("model2_count", exp_q.size(), 256);
        check("model2_last", exp_q[255], {16'h30FF, 8'hA5});
        run_dl("cmd_256", 8'd2, 1'b1);

        // Skip record ahead of a load record
        stream = '{8'h05, 8'h03, 8'h41, 8'h42, 8'h43, 8'h01, 8'h04, 8'h10, 8'h20,
                   8'hDE, 8'hAD, 8'h02, 8'h02, 8'h00, 8'h60};
        model_cmd();
        check("model3_count", exp_q.size(), 2);
        check("model3_first", exp_q[0], {16'h2010, 8'hDE});
        run_dl("cmd_skip", 8'd2, 1'b1);
        check("cmd_skip_exec_lit", execute_addr, 16'h6000);

        // RAM back-pressure on the first write
        stream = '{8'h01, 8'h04, 8'h00, 8'h70, 8'h99, 8'h77};
        model_cmd();
        stall_cnt = 3;
        max_run = 0;
        run_dl("cmd_stall", 8'd2, 1'b1);
        check("stall_wr_cycles", max_run, 4);

        // Truncated load record, then a fresh download clears err
        stream = '{8'h01, 8'h05, 8'h00, 8'h40, 8'hAA};
        model_cmd();
        check("model5_clean", exp_clean, 0);
        run_dl("cmd_trunc", 8'd2, 1'b1);
        check("trunc_err_lit", err, 1);
        stream = '{8'h02, 8'h02, 8'h34, 8'h12};
        model_cmd();
        run_dl("cmd_after_trunc", 8'd2, 1'b1);
        check("after_trunc_exec_lit", execute_addr, 16'h1234);

        // Raw image wrapping from the top of memory
        stream = '{8'h11, 8'h22, 8'h33};
        model_raw(16'hFFFF);
        check("model6_wrap", exp_q[1], {16'h0000, 8'h22});
        run_dl("raw_wrap", 8'd3, 1'b0);

        // Unknown index is ignored
        stream = '{8'h01, 8'h03, 8'h00, 8'h40, 8'h55};
        exp_q.delete();
        pulses = 0;
        start_dl(8'd7, 1'b0);
        foreach (stream[k]) send_byte(stream[k]);
        end_dl();
        check("ignored_pulse", pulses, 0);
        $display("ignored_index: %0d checks so far, %0d errors", checks, errors);

        // Reset in the middle of a data record
        stream = '{8'h01, 8'h05, 8'h00, 8'h40, 8'hAA, 8'hBB};
        model_cmd();
        pulses = 0;
        start_dl(8'd2, 1'b1);
        foreach (stream[k]) send_byte(stream[k]);
        reset_n = 1'b0;
        tick();
        check("midrst_download", loader_download, 0);
        check("midrst_wr_wait", {loader_wr, ioctl_wait, loader_addr, loader_data}, 0);
        check("midrst_exec", {execute_enable, execute_addr}, 0);
        check("midrst_err", err, 0);
        reset_n = 1'b1;
        tick();
        send_byte(8'hCC);
        send_byte(8'h02);
        end_dl();
        check("midrst_pulse", pulses, 0);
        check("midrst_drain", exp_q.size(), 0);
        $display("reset_mid_data: %0d checks so far, %0d errors", checks, errors);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
